// File: rtl/nn_cfg_loader_pkg.sv
// Shared constants, state encoding and index width helpers
// for the streaming layer configuration loader.
package nn_cfg_loader_pkg;

  localparam int NUM_NEURON_LAYER1 = 30;
  localparam int NUM_NEURON_LAYER2 = 30;
  localparam int NUM_NEURON_LAYER3 = 10;
  localparam int NUM_WEIGHT_LAYER1 = 784;
  localparam int NUM_WEIGHT_LAYER2 = 30;
  localparam int NUM_WEIGHT_LAYER3 = 30;

  localparam int DEF_NUM_LAYERS = 3;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [47:0] DEF_LAYER_NEURONS = {
    16'(NUM_NEURON_LAYER3),
    16'(NUM_NEURON_LAYER2),
    16'(NUM_NEURON_LAYER1)
  };
  localparam logic [47:0] DEF_LAYER_WEIGHTS = {
    16'(NUM_WEIGHT_LAYER3),
    16'(NUM_WEIGHT_LAYER2),
    16'(NUM_WEIGHT_LAYER1)
  };

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WEIGHT = 2'd1;
  localparam logic [1:0] S_BIAS   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_WEIGHT = S_WEIGHT,
    ST_BIAS   = S_BIAS,
    ST_FINISH = S_FINISH
  } state_e;

  function automatic int max_field(
    input logic [255:0] vec,
    input int n
  );
    int m;
    m = 0;
    for (int i = 0; i < n; i++)
      if (int'(vec[16*i +: 16]) > m)
        m = int'(vec[16*i +: 16]);
    return m;
  endfunction

  // Bits needed to hold any value 0..maxval.
  function automatic int idx_w(input int maxval);
    return $clog2(maxval + 1);
  endfunction

  localparam int LAYER_IDX_W  = idx_w(DEF_NUM_LAYERS);
  localparam int NEURON_IDX_W =
    idx_w(max_field(256'(DEF_LAYER_NEURONS), DEF_NUM_LAYERS));
  localparam int WCNT_W       =
    idx_w(max_field(256'(DEF_LAYER_WEIGHTS), DEF_NUM_LAYERS));

endpackage

// File: rtl/nn_cfg_index_gen.sv
// Nested layer/neuron/word counters walking the image order:
// per neuron, W weight positions then one bias position.
module nn_cfg_index_gen
  import nn_cfg_loader_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter logic [16*NUM_LAYERS-1:0] LAYER_NEURONS =
    DEF_LAYER_NEURONS,
  parameter logic [16*NUM_LAYERS-1:0] LAYER_WEIGHTS =
    DEF_LAYER_WEIGHTS,
  parameter int LW = LAYER_IDX_W,
  parameter int NW = NEURON_IDX_W,
  parameter int WW = WCNT_W
) (
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  input  logic          clear,
  input  logic          advance,
  output logic [LW-1:0] layer,
  output logic [NW-1:0] neuron,
  output logic          is_last_weight,
  output logic          is_last_neuron,
  output logic          is_last_layer
);

  logic [WW-1:0] wcnt;
  logic [15:0]   cur_n;
  logic [15:0]   cur_w;
  logic          is_bias;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_chk
    if (LAYER_NEURONS[16*g +: 16] == 16'd0 ||
        LAYER_WEIGHTS[16*g +: 16] == 16'd0) begin : g_bad
      $error("nn_cfg_index_gen: layer %0d has zero size", g + 1);
    end
  end

  // Select the neuron/weight counts of the current layer.
  always_comb begin
    cur_n = '0;
    cur_w = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (layer == LW'(i + 1)) begin
        cur_n = LAYER_NEURONS[16*i +: 16];
        cur_w = LAYER_WEIGHTS[16*i +: 16];
      end
  end

  assign is_bias        = 32'(wcnt) == 32'(cur_w);
  assign is_last_weight = 32'(wcnt) == 32'(cur_w) - 32'd1;
  assign is_last_neuron = 32'(neuron) == 32'(cur_n) - 32'd1;
  assign is_last_layer  = layer == LW'(NUM_LAYERS);

  // Step one image position per accepted beat.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      layer  <= '0;
      neuron <= '0;
      wcnt   <= '0;
    end else if (clear) begin
      layer  <= LW'(1);
      neuron <= '0;
      wcnt   <= '0;
    end else if (advance) begin
      if (is_bias) begin
        wcnt <= '0;
        if (!is_last_neuron) begin
          neuron <= neuron + 1'b1;
        end else if (!is_last_layer) begin
          layer  <= layer + 1'b1;
          neuron <= '0;
        end
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_cfg_loader.sv
// Streams a packed weight/bias image from a valid/ready source
// onto the per-layer configuration bus.
module nn_cfg_loader
  import nn_cfg_loader_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [16*NUM_LAYERS-1:0] LAYER_NEURONS =
    DEF_LAYER_NEURONS,
  parameter logic [16*NUM_LAYERS-1:0] LAYER_WEIGHTS =
    DEF_LAYER_WEIGHTS
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [31:0]           config_layer_num,
  output logic [31:0]           config_neuron_num,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic                  biasValid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           words_loaded
);

  localparam int LW = idx_w(NUM_LAYERS);
  localparam int NW =
    idx_w(max_field(256'(LAYER_NEURONS), NUM_LAYERS));
  localparam int WW =
    idx_w(max_field(256'(LAYER_WEIGHTS), NUM_LAYERS));

  state_e        state;
  logic          accept;
  logic          idx_clear;
  logic [LW-1:0] layer_idx;
  logic [NW-1:0] neuron_idx;
  logic          last_w;
  logic          last_n;
  logic          last_l;

  assign cfg_ready = (state == ST_WEIGHT || state == ST_BIAS)
                   && !abort;
  assign accept    = cfg_valid && cfg_ready;
  assign busy      = state != ST_IDLE;
  assign idx_clear = state == ST_IDLE && start && !abort;

  nn_cfg_index_gen #(
    .NUM_LAYERS   (NUM_LAYERS),
    .LAYER_NEURONS(LAYER_NEURONS),
    .LAYER_WEIGHTS(LAYER_WEIGHTS),
    .LW           (LW),
    .NW           (NW),
    .WW           (WW)
  ) u_idx (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .clear         (idx_clear),
    .advance       (accept),
    .layer         (layer_idx),
    .neuron        (neuron_idx),
    .is_last_weight(last_w),
    .is_last_neuron(last_n),
    .is_last_layer (last_l)
  );

  // Load sequencer plus registered strobes, indices and beat count.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state             <= ST_IDLE;
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      done              <= 1'b0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      weightValue       <= '0;
      biasValue         <= '0;
      words_loaded      <= '0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      done        <= 1'b0;
      if (accept) begin
        config_layer_num  <= 32'(layer_idx);
        config_neuron_num <= 32'(neuron_idx);
        if (state == ST_WEIGHT) begin
          weightValid <= 1'b1;
          weightValue <= cfg_data;
        end else begin
          biasValid <= 1'b1;
          biasValue <= cfg_data;
        end
        if (words_loaded != '1)
          words_loaded <= words_loaded + 32'd1;
      end
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              state        <= ST_WEIGHT;
              words_loaded <= '0;
            end
          end
          ST_WEIGHT: begin
            if (accept && last_w)
              state <= ST_BIAS;
          end
          ST_BIAS: begin
            if (accept)
              state <= (last_n && last_l) ? ST_FINISH
                                          : ST_WEIGHT;
          end
          ST_FINISH: begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
